// File: rtl/npc_pkg.sv
// npc_pkg: shared constants for the write-back slice.
//   Holds the load funct3 encodings, the write-back FSM state encoding and
//   the default datapath / register-index widths.
package npc_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int REG_NUM_BIT_DEF = 5;

  // Load funct3 encodings (RV32I)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// load_formatter: selects the byte/half lane of a load word and extends it.
// Latency: purely combinational, 0 cycles.
// Backpressure: none (no handshake).
// Ports: funct3 (load type), addr_lo (address bits [1:0]), rdata (raw word),
//        data (aligned and extended result). Unknown funct3 passes rdata through.
module load_formatter
  import npc_pkg::*;
(
  input  logic [2:0]                funct3,
  input  logic [1:0]                addr_lo,
  input  logic [DATA_WIDTH_DEF-1:0] rdata,
  output logic [DATA_WIDTH_DEF-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Misaligned halves are not trapped; only addr_lo[1] picks the lane.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage feeding the register-file write port.
// Latency: non-load retires 1 cycle after transfer; load retires 1 cycle after mem_rvalid.
// Backpressure: ex_ready is high only in IDLE; a load holds it low until its data returns.
// Ports: clk/rst_n; ex_* valid/ready instruction input from execute; mem_rvalid/mem_rdata
//        load response; rf_wen/rf_waddr/rf_wdata registered RF write; commit retire pulse;
//        load_err sticky timeout flag.
// Optional: define WB_LOAD_TIMEOUT_EN to abandon loads after LOAD_TIMEOUT wait cycles
//           and raise load_err; otherwise load_err is 0 and loads wait indefinitely.
module wb_stage
  import npc_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int REG_NUM_BIT  = REG_NUM_BIT_DEF,
  parameter int LOAD_TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [REG_NUM_BIT-1:0] ex_rd,
  input  logic                   ex_rd_wen,
  input  logic [DATA_WIDTH-1:0]  ex_result,
  input  logic                   ex_is_load,
  input  logic [2:0]             ex_funct3,
  input  logic [1:0]             ex_addr_lo,
  input  logic                   mem_rvalid,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic                   commit,
  output logic                   load_err
);

  wb_state_e state_q, state_d;

  // Load context held while waiting for memory
  logic [REG_NUM_BIT-1:0] ld_rd_q;
  logic                   ld_wen_q;
  logic [2:0]             ld_f3_q;
  logic [1:0]             ld_lo_q;

  logic                   retire;
  logic                   capture;
  logic                   wen_d;
  logic [REG_NUM_BIT-1:0] waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [DATA_WIDTH-1:0]  fmt_data;
  logic                   load_tmo;

  load_formatter u_fmt (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .rdata   (mem_rdata),
    .data    (fmt_data)
  );

  assign ex_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    capture = 1'b0;
    wen_d   = 1'b0;
    waddr_d = ex_rd;
    wdata_d = ex_result;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            capture = 1'b1;
            state_d = ST_WAIT_MEM;
          end else begin
            retire = 1'b1;
            wen_d  = ex_rd_wen && (ex_rd != '0);
          end
        end
      end
      ST_WAIT_MEM: begin
        waddr_d = ld_rd_q;
        wdata_d = fmt_data;
        // Data arriving on the limit cycle takes priority over the timeout.
        if (mem_rvalid) begin
          retire  = 1'b1;
          wen_d   = ld_wen_q && (ld_rd_q != '0);
          state_d = ST_IDLE;
        end else if (load_tmo) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      commit   <= 1'b0;
      ld_rd_q  <= '0;
      ld_wen_q <= 1'b0;
      ld_f3_q  <= 3'd0;
      ld_lo_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rf_wen  <= wen_d;
      commit  <= retire;
      // Address/data hold their last retired values between retirements.
      if (retire) begin
        rf_waddr <= waddr_d;
        rf_wdata <= wdata_d;
      end
      if (capture) begin
        ld_rd_q  <= ex_rd;
        ld_wen_q <= ex_rd_wen;
        ld_f3_q  <= ex_funct3;
        ld_lo_q  <= ex_addr_lo;
      end
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the LOAD_TIMEOUT-th consecutive wait cycle without data.
  assign load_tmo = (state_q == ST_WAIT_MEM) && !mem_rvalid &&
                    (tmo_cnt == CNT_W'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT_MEM) && !mem_rvalid && !load_tmo)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (load_tmo)
        err_q <= 1'b1;
    end
  end

  assign load_err = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (LOAD_TIMEOUT > 0);
  assign load_tmo       = 1'b0;
  assign load_err       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_rd_wen, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen, commit, load_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last retired address/data and the sticky error flag
  logic [4:0]  exp_waddr = 5'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic        exp_err   = 1'b0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(32), .REG_NUM_BIT(5), .LOAD_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
    .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit(commit), .load_err(load_err)
  );

  // Load result from the ISA rules using shifts/masks on the word.
  function automatic logic [31:0] fmt_ref(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    int unsigned b, h, sh_b, sh_h;
    sh_b = 8 * int'(lo);
    sh_h = 16 * (int'(lo) / 2);
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    ex_valid   = 1'b0;
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
    tick();
    n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL %s rf_wen got %0b exp 0", tag, rf_wen); end
    n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL %s commit got %0b exp 0", tag, commit); end
    n_tests++; if (rf_waddr !== exp_waddr) begin n_fail++; $display("FAIL %s waddr hold got %0d exp %0d", tag, rf_waddr, exp_waddr); end
    n_tests++; if (rf_wdata !== exp_wdata) begin n_fail++; $display("FAIL %s wdata hold got %h exp %h", tag, rf_wdata, exp_wdata); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL %s ex_ready got %0b exp 1", tag, ex_ready); end
    n_tests++; if (load_err !== exp_err) begin n_fail++; $display("FAIL %s load_err got %0b exp %0b", tag, load_err, exp_err); end
    mem_rvalid = 1'b0;
  endtask

  // Presents one non-load for one cycle and checks its retirement; leaves ex_valid high.
  task automatic run_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                         input string tag);
    logic ew;
    ew = wen && (rd != 5'd0);
    ex_valid   = 1'b1;  ex_is_load = 1'b0;
    ex_rd      = rd;    ex_rd_wen  = wen;  ex_result = res;
    ex_funct3  = 3'($urandom); ex_addr_lo = 2'($urandom);
    mem_rvalid = 1'($urandom); mem_rdata  = $urandom;
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL %s pre ex_ready got %0b exp 1", tag, ex_ready); end
    tick();
    n_tests++; if (rf_wen !== ew) begin n_fail++; $display("FAIL %s rf_wen got %0b exp %0b", tag, rf_wen, ew); end
    n_tests++; if (commit !== 1'b1) begin n_fail++; $display("FAIL %s commit got %0b exp 1", tag, commit); end
    n_tests++; if (rf_waddr !== rd) begin n_fail++; $display("FAIL %s waddr got %0d exp %0d", tag, rf_waddr, rd); end
    n_tests++; if (rf_wdata !== res) begin n_fail++; $display("FAIL %s wdata got %h exp %h", tag, rf_wdata, res); end
    exp_waddr = rd;
    exp_wdata = res;
  endtask

  // Issues a load; rvalid comes on the delay-th wait cycle. Execute inputs are
  // scrambled while waiting and must be ignored.
  task automatic run_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w,
                          input logic [4:0] rd, input logic wen, input int delay,
                          input string tag);
    logic [31:0] ed;
    logic        ew;
    ed = fmt_ref(f3, lo, w);
    ew = wen && (rd != 5'd0);
    ex_valid   = 1'b1;  ex_is_load = 1'b1;
    ex_rd      = rd;    ex_rd_wen  = wen;  ex_result = $urandom;
    ex_funct3  = f3;    ex_addr_lo = lo;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    for (int c = 1; c <= delay; c++) begin
      tick();
      n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL %s wait%0d ex_ready got %0b exp 0", tag, c, ex_ready); end
      n_tests++; if (commit !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL %s wait%0d commit/wen got %0b/%0b exp 0/0", tag, c, commit, rf_wen); end
      ex_valid   = 1'($urandom); ex_is_load = 1'($urandom);
      ex_rd      = 5'($urandom); ex_rd_wen  = 1'($urandom);
      ex_funct3  = 3'($urandom); ex_addr_lo = 2'($urandom); ex_result = $urandom;
      mem_rvalid = (c == delay);
      mem_rdata  = (c == delay) ? w : $urandom;
    end
    tick();
    ex_valid   = 1'b0;
    mem_rvalid = 1'b0;
    n_tests++; if (rf_wen !== ew) begin n_fail++; $display("FAIL %s rf_wen got %0b exp %0b", tag, rf_wen, ew); end
    n_tests++; if (commit !== 1'b1) begin n_fail++; $display("FAIL %s commit got %0b exp 1", tag, commit); end
    n_tests++; if (rf_waddr !== rd) begin n_fail++; $display("FAIL %s waddr got %0d exp %0d", tag, rf_waddr, rd); end
    n_tests++; if (rf_wdata !== ed) begin n_fail++; $display("FAIL %s wdata got %h exp %h", tag, rf_wdata, ed); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL %s post ex_ready got %0b exp 1", tag, ex_ready); end
    exp_waddr = rd;
    exp_wdata = ed;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_rd_wen = 1'b0;
    ex_result = 32'd0; ex_funct3 = 3'd0; ex_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #23;
    n_tests++; if (rf_wen !== 1'b0 || commit !== 1'b0) begin n_fail++; $display("FAIL reset wen/commit got %0b/%0b exp 0/0", rf_wen, commit); end
    n_tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset waddr/wdata got %0d/%h exp 0/0", rf_waddr, rf_wdata); end
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset load_err got %0b exp 0", load_err); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset ex_ready got %0b exp 1", ex_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("reset_idle");
  endtask

  task automatic test_alu_single();
    run_alu(5'd5, 1'b1, 32'h0000_1234, "alu_rd5");
    idle_check("alu_rd5_after");
  endtask

  task automatic test_back_to_back();
    run_alu(5'd1, 1'b1, 32'hA5A5_0001, "b2b_1");
    run_alu(5'd2, 1'b1, 32'hA5A5_0002, "b2b_2");
    run_alu(5'd3, 1'b1, 32'hA5A5_0003, "b2b_3");
    idle_check("b2b_after");
  endtask

  task automatic test_loads();
    run_load(3'b000, 2'd3, 32'h80FF_0000, 5'd9, 1'b1, 4, "lb");
    n_tests++; if (rf_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_const wdata got %h exp ffffff80", rf_wdata); end
    idle_check("lb_after");
    run_load(3'b100, 2'd3, 32'h80FF_0000, 5'd9, 1'b1, 4, "lbu");
    n_tests++; if (rf_wdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_const wdata got %h exp 00000080", rf_wdata); end
    run_load(3'b101, 2'd2, 32'hBEEF_1234, 5'd10, 1'b1, 1, "lhu");
    n_tests++; if (rf_wdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_const wdata got %h exp 0000beef", rf_wdata); end
    run_load(3'b001, 2'd0, 32'h1234_8001, 5'd11, 1'b1, 2, "lh");
    run_load(3'b010, 2'd1, 32'hDEAD_BEEF, 5'd12, 1'b1, 3, "lw_mis");
    run_load(3'b111, 2'd2, 32'h0BAD_F00D, 5'd13, 1'b1, 1, "raw_f3");
    idle_check("loads_after");
  endtask

  task automatic test_rd_zero();
    run_alu(5'd0, 1'b1, 32'h5555_AAAA, "alu_rd0");
    run_load(3'b010, 2'd0, 32'h1111_2222, 5'd0, 1'b1, 2, "load_rd0");
    run_alu(5'd7, 1'b0, 32'h0000_0077, "alu_nowen");
    idle_check("rd0_after");
  endtask

`ifdef WB_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    run_load(3'b010, 2'd0, 32'hCAFE_0001, 5'd4, 1'b1, 8, "tmo_edge_win");
    idle_check("tmo_edge_after");
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd6; ex_rd_wen = 1'b1;
    ex_funct3 = 3'b010; ex_addr_lo = 2'd0; mem_rvalid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ex_valid = 1'b0;
      n_tests++; if (load_err !== 1'b0 || ex_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_wait%0d err/ready got %0b/%0b exp 0/0", c, load_err, ex_ready); end
    end
    tick();
    exp_err = 1'b1;
    n_tests++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL tmo load_err got %0b exp 1", load_err); end
    n_tests++; if (commit !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL tmo commit/wen got %0b/%0b exp 0/0", commit, rf_wen); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL tmo ex_ready got %0b exp 1", ex_ready); end
    idle_check("tmo_sticky1");
    run_alu(5'd8, 1'b1, 32'h0000_0808, "tmo_alu");
    idle_check("tmo_sticky2");
  endtask
`else
  task automatic test_timeout();
    run_load(3'b000, 2'd1, 32'h0000_7F00, 5'd14, 1'b1, 20, "long_wait");
    idle_check("long_wait_after");
  endtask
`endif

  task automatic test_reset_mid_wait();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_rd_wen = 1'b1;
    ex_funct3 = 3'b010; ex_addr_lo = 2'd0; mem_rvalid = 1'b0;
    tick();
    ex_valid = 1'b0;
    n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rstwait pre ex_ready got %0b exp 0", ex_ready); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_waddr = 5'd0; exp_wdata = 32'd0; exp_err = 1'b0;
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait ex_ready got %0b exp 1", ex_ready); end
    n_tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || load_err !== 1'b0) begin n_fail++; $display("FAIL rstwait regs got %0d/%h/%0b exp 0/0/0", rf_waddr, rf_wdata, load_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    n_tests++; if (rf_wen !== 1'b0 || commit !== 1'b0) begin n_fail++; $display("FAIL rstwait late_rvalid wen/commit got %0b/%0b exp 0/0", rf_wen, commit); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait late ex_ready got %0b exp 1", ex_ready); end
    idle_check("rstwait_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        run_load(3'($urandom), 2'($urandom), $urandom, 5'($urandom), 1'($urandom),
                 int'($urandom_range(1, 6)), "rand_load");
      else
        run_alu(5'($urandom), 1'($urandom), $urandom, "rand_alu");
      if ($urandom_range(0, 3) == 0)
        idle_check("rand_idle");
    end
    idle_check("rand_end");
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_loads();
    test_rd_zero();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
